// File: rtl/ren_img_loader.sv
// rtl/ren_img_loader.sv - packs 8-bit pixels into 24-bit words and writes them to accelerator image memory over Wishbone
module ren_img_loader #(
    parameter logic [31:0] IMG_BASE_ADDR = 32'h3000_0100,
    parameter int unsigned ACK_TIMEOUT   = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic [7:0]  inst_no_i,
    input  logic [5:0]  word_cnt_i,
    input  logic        pix_valid_i,
    input  logic [7:0]  pix_data_i,
    output logic        pix_ready_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    inst_q, inst_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    lane0_q, lane0_d;
    logic [7:0]    lane1_q, lane1_d;
    logic [7:0]    lane2_q, lane2_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          err_q, err_d;
    logic          cyc_q, ready_q, busy_q, done_q;

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        lane0_d    = lane0_q;
        lane1_d    = lane1_q;
        lane2_d    = lane2_q;
        tmo_d      = tmo_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (word_cnt_i != 6'd0) begin
                        inst_d     = inst_no_i;
                        cnt_d      = word_cnt_i;
                        word_idx_d = 6'd0;
                        byte_idx_d = 2'd0;
                        state_d    = S_COLLECT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_COLLECT: begin
                if (pix_valid_i) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    lane0_d = pix_data_i;
                        2'd1:    lane1_d = pix_data_i;
                        default: lane2_d = pix_data_i;
                    endcase
                    // Bus address/data are built straight from the third byte so they are valid on the first WRITE cycle.
                    if (byte_idx_q == 2'd2) begin
                        byte_idx_d = 2'd0;
                        tmo_d      = '0;
                        sel_d      = 4'hF;
                        adr_d      = IMG_BASE_ADDR + {inst_q, 24'd0} + {24'd0, word_idx_q, 2'b00};
                        dat_d      = {8'd0, pix_data_i, lane1_q, lane0_q};
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wbm_ack_i) begin
                    word_idx_d = word_idx_q + 6'd1;
                    byte_idx_d = 2'd0;
                    if (word_idx_q == cnt_q - 6'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so each one tracks the current state exactly.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            inst_q     <= '0;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            lane0_q    <= '0;
            lane1_q    <= '0;
            lane2_q    <= '0;
            tmo_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            err_q      <= 1'b0;
            cyc_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            lane0_q    <= lane0_d;
            lane1_q    <= lane1_d;
            lane2_q    <= lane2_d;
            tmo_q      <= tmo_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            cyc_q      <= (state_d == S_WRITE);
            ready_q    <= (state_d == S_COLLECT);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign pix_ready_o = ready_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = cyc_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ren_img_loader.sv
// tb/tb_ren_img_loader.sv - self-checking bench for ren_img_loader
module tb_ren_img_loader;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam int          TMO  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  inst = 8'd0;
    logic [5:0]  word_cnt = 6'd0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        ack = 1'b0;
    logic        pix_ready, cyc, stb, we, busy, done, err;
    logic [3:0]  sel;
    logic [31:0] adr, dat;

    ren_img_loader #(.IMG_BASE_ADDR(BASE), .ACK_TIMEOUT(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .start_i    (start),
        .inst_no_i  (inst),
        .word_cnt_i (word_cnt),
        .pix_valid_i(pix_valid),
        .pix_data_i (pix_data),
        .pix_ready_o(pix_ready),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat),
        .wbm_ack_i  (ack),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wishbone slave and bus observer
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          stb_run = 0;
    int          last_run = 0;
    int          done_cycles = 0;
    logic [31:0] prev_adr, prev_dat;
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    logic [3:0]  wr_sel_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            ack = 1'b0;
            wait_cnt = 0;
            stb_run = 0;
        end else begin
            if (done) done_cycles++;
            if (cyc && stb) begin
                if (stb_run > 0) begin
                    chk("adr_stable", adr, prev_adr);
                    chk("dat_stable", dat, prev_dat);
                end
                chk("ready_in_write", 32'(pix_ready), 32'd0);
                chk("we_in_write", 32'(we), 32'd1);
                prev_adr = adr;
                prev_dat = dat;
                stb_run++;
                if (!ack && ack_delay >= 0 && wait_cnt >= ack_delay) begin
                    ack = 1'b1;
                    wr_adr_q.push_back(adr);
                    wr_dat_q.push_back(dat);
                    wr_sel_q.push_back(sel);
                end else if (!ack) begin
                    wait_cnt++;
                end
            end else begin
                ack = 1'b0;
                wait_cnt = 0;
                if (stb_run > 0) last_run = stb_run;
                stb_run = 0;
            end
        end
    end

    // Pixel source with configurable idle gap after every accepted byte
    logic [7:0] pix_q[$];
    logic [7:0] stim_q[$];
    int         pix_gap = 0;
    int         gap_cnt = 0;
    int         consumed = 0;
    bit         hs_next = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pix_valid = 1'b0;
            hs_next = 1'b0;
            gap_cnt = 0;
        end else begin
            if (hs_next) begin
                void'(pix_q.pop_front());
                consumed++;
                gap_cnt = pix_gap;
                hs_next = 1'b0;
            end
            if (gap_cnt > 0) begin
                pix_valid = 1'b0;
                gap_cnt--;
            end else if (pix_q.size() > 0) begin
                pix_valid = 1'b1;
                pix_data = pix_q[0];
            end else begin
                pix_valid = 1'b0;
            end
            hs_next = pix_valid && pix_ready;
        end
    end

    task automatic run_load(input logic [7:0] i_inst, input int n, input int dly, input int gap,
                            input bit never_ack, input bit poke);
        int          loops;
        int          exp_wr;
        int          exp_cons;
        logic [31:0] ea;
        logic [31:0] ed;
        pix_q = stim_q;
        for (int k = 0; k < 3; k++) pix_q.push_back(8'($urandom));
        consumed = 0;
        wr_adr_q.delete();
        wr_dat_q.delete();
        wr_sel_q.delete();
        ack_delay = never_ack ? -1 : dly;
        pix_gap = gap;
        done_cycles = 0;
        last_run = 0;
        @(negedge clk);
        start = 1'b1;
        inst = i_inst;
        word_cnt = 6'(n);
        @(negedge clk);
        start = 1'b0;
        inst = 8'($urandom);
        word_cnt = 6'($urandom);
        chk("err_cleared_on_start", 32'(err), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
        loops = 0;
        while (done_cycles == 0 && loops < 20000) begin
            if (poke && busy && (loops % 7 == 3)) begin
                start = 1'b1;
                inst = 8'($urandom);
                word_cnt = 6'($urandom_range(32, 1));
            end
            @(negedge clk);
            start = 1'b0;
            loops++;
        end
        chk("done_seen", 32'(done_cycles > 0), 32'd1);
        if (n == 0) chk("zero_cnt_done_latency", 32'(loops <= 2), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_pulse_cycles", 32'(done_cycles), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("err_after_done", 32'(err), 32'(never_ack && n > 0));
        exp_wr = never_ack ? 0 : n;
        exp_cons = never_ack ? ((n > 0) ? 3 : 0) : 3 * n;
        if (never_ack && n > 0) chk("timeout_stb_cycles", 32'(last_run), 32'(TMO));
        chk("bytes_consumed", 32'(consumed), 32'(exp_cons));
        chk("write_count", 32'(wr_adr_q.size()), 32'(exp_wr));
        for (int w = 0; w < exp_wr && w < wr_adr_q.size(); w++) begin
            ea = BASE + 32'(i_inst) * 32'h0100_0000 + 32'(w) * 32'd4;
            ed = 32'(stim_q[3*w]) + 32'(stim_q[3*w+1]) * 32'd256 + 32'(stim_q[3*w+2]) * 32'd65536;
            chk("write_adr", wr_adr_q[w], ea);
            chk("write_dat", wr_dat_q[w], ed);
            chk("write_sel", 32'(wr_sel_q[w]), 32'hF);
        end
        pix_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cyc"}, 32'(cyc), 32'd0);
        chk({tag, "_stb"}, 32'(stb), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_adr"}, adr, 32'd0);
        chk({tag, "_dat"}, dat, 32'd0);
    endtask

    initial begin
        int  n;
        bit  found;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full 32-word load with an incrementing pixel ramp and immediate ack
        stim_q.delete();
        for (int k = 0; k < 96; k++) stim_q.push_back(8'(k));
        run_load(8'd0, 32, 0, 0, 1'b0, 1'b0);
        if (wr_adr_q.size() == 32) begin
            chk("ramp_first_adr", wr_adr_q[0], 32'h3000_0100);
            chk("ramp_first_dat", wr_dat_q[0], 32'h0002_0100);
            chk("ramp_last_adr", wr_adr_q[31], 32'h3000_017C);
            chk("ramp_last_dat", wr_dat_q[31], 32'h005F_5E5D);
        end

        // Single word to instance 2
        stim_q = '{8'hAA, 8'hBB, 8'hCC};
        run_load(8'd2, 1, 0, 0, 1'b0, 1'b0);
        if (wr_adr_q.size() == 1) begin
            chk("single_adr", wr_adr_q[0], 32'h3200_0100);
            chk("single_dat", wr_dat_q[0], 32'h00CC_BBAA);
        end

        // Slow ack, gappy pixel stream, ignored start pulses while busy
        stim_q.delete();
        for (int k = 0; k < 18; k++) stim_q.push_back(8'($urandom));
        run_load(8'd7, 6, 5, 3, 1'b0, 1'b1);

        // Zero-length load
        stim_q.delete();
        run_load(8'd3, 0, 0, 0, 1'b0, 1'b0);

        // Slave never acks: timeout, then a normal load clears the error
        stim_q.delete();
        for (int k = 0; k < 6; k++) stim_q.push_back(8'($urandom));
        run_load(8'd4, 2, 0, 0, 1'b1, 1'b0);
        stim_q.delete();
        for (int k = 0; k < 6; k++) stim_q.push_back(8'($urandom));
        run_load(8'd9, 2, 1, 1, 1'b0, 1'b0);

        // Randomised loads, including high instance numbers that wrap the address
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(32, 1));
            stim_q.delete();
            for (int k = 0; k < 3 * n; k++) stim_q.push_back(8'($urandom));
            run_load(8'($urandom), n, int'($urandom_range(5, 0)), int'($urandom_range(3, 0)),
                     1'b0, 1'($urandom));
        end

        // Asynchronous reset in the middle of the write of word 5
        stim_q.delete();
        for (int k = 0; k < 30; k++) stim_q.push_back(8'($urandom));
        pix_q = stim_q;
        consumed = 0;
        wr_adr_q.delete();
        wr_dat_q.delete();
        wr_sel_q.delete();
        ack_delay = 3;
        pix_gap = 0;
        @(negedge clk);
        start = 1'b1;
        inst = 8'd5;
        word_cnt = 6'd10;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(posedge clk);
            #2;
            if (cyc && wr_adr_q.size() == 5) found = 1'b1;
        end
        chk("reached_word5_write", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        pix_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
        stim_q.delete();
        for (int k = 0; k < 3; k++) stim_q.push_back(8'($urandom));
        run_load(8'd1, 1, 2, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
